// File: rtl/ptp_tx_gen.sv
`timescale 1ns/1ps
// ptp_tx_gen
//   Builds and drives a complete layer-2 PTP event frame (Sync / Delay_Req) on a
//   GMII TX interface with one-step timestamping: the RTC value present on the
//   SFD cycle is placed into originTimestamp of the same frame.
//
// Ports
//   gmii_clk     in   125 MHz TX byte clock, rising edge
//   rst          in   asynchronous active-high reset
//   rtc_time_in  in   {sec[5:0], ns[29:0]} real-time clock
//   tx_req       in   frame request, accepted only while idle
//   tx_msg_id    in   PTP messageType
//   tx_seq_id    in   PTP sequenceId
//   tx_busy      out  frame in progress (preamble through last IFG cycle)
//   tx_done      out  pulse on the last FCS byte
//   tx_ts_out    out  timestamp captured on the SFD cycle
//   gmii_tx_en   out  GMII TX enable
//   gmii_txd     out  GMII TX data
module ptp_tx_gen #(
    parameter logic [47:0] SRC_MAC   = 48'h00_0A_35_00_01_02,
    parameter logic [63:0] CLOCK_ID  = 64'h000A35FFFE000102,
    parameter logic [15:0] PORT_NUM  = 16'h0001,
    parameter logic [7:0]  DOMAIN    = 8'h00,
    parameter int          IFG_BYTES = 12
) (
    input  logic        gmii_clk,
    input  logic        rst,
    input  logic [35:0] rtc_time_in,
    input  logic        tx_req,
    input  logic [3:0]  tx_msg_id,
    input  logic [15:0] tx_seq_id,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [35:0] tx_ts_out,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd
);

    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;  // reflected 04C11DB7

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DATA,
        S_FCS,
        S_IFG
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [3:0]  msg_q;
    logic [15:0] seq_q;
    logic [31:0] crc_q;
    logic [31:0] fcs;
    logic [7:0]  ctrl;
    logic [7:0]  data_byte;
    logic [5:0]  data_idx;
    logic [8:0]  bit_lo;
    logic [479:0] frame;

    // Byte-wide reflected CRC-32 step: data enters LSB first, matching GMII bit order.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        case (msg_q)
            4'd0:    ctrl = 8'h00;
            4'd1:    ctrl = 8'h01;
            default: ctrl = 8'h05;
        endcase
    end

    // Whole 60-byte payload (dst MAC through pad), first byte in the MSBs.
    // originTimestamp reads tx_ts_out, which is loaded at the end of the SFD cycle
    // and therefore already valid on DATA byte 0.
    assign frame = {48'h01_1B_19_00_00_00, SRC_MAC, 16'h88F7,
                    4'h0, msg_q, 8'h02, 16'd44, DOMAIN, 8'h00, 16'h0000,
                    64'd0, 32'd0, CLOCK_ID, PORT_NUM, seq_q, ctrl, 8'h7F,
                    42'd0, tx_ts_out[35:30], 2'b00, tx_ts_out[29:0], 16'h0000};

    assign data_idx  = (cnt < 8'd60) ? cnt[5:0] : 6'd0;
    assign bit_lo    = {6'd59 - data_idx, 3'b000};
    assign data_byte = frame[bit_lo +: 8];
    assign fcs       = ~crc_q;

    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            msg_q     <= 4'd0;
            seq_q     <= 16'd0;
            crc_q     <= 32'd0;
            tx_ts_out <= 36'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && tx_req) begin
                msg_q <= tx_msg_id;
                seq_q <= tx_seq_id;
            end
            if (state == S_SFD) begin
                tx_ts_out <= rtc_time_in;
                crc_q     <= 32'hFFFF_FFFF;
            end else if (state == S_DATA) begin
                crc_q <= crc_byte(crc_q, data_byte);
            end
        end
    end

    // Outputs decode straight from state so an async reset blanks the line at once.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + 8'd1;
        tx_busy    = 1'b1;
        tx_done    = 1'b0;
        gmii_tx_en = 1'b0;
        gmii_txd   = 8'h00;
        case (state)
            S_IDLE: begin
                tx_busy = 1'b0;
                cnt_nxt = 8'd0;
                if (tx_req) state_nxt = S_PRE;
            end
            S_PRE: begin
                gmii_tx_en = 1'b1;
                gmii_txd   = 8'h55;
                if (cnt == 8'd6) begin
                    state_nxt = S_SFD;
                    cnt_nxt   = 8'd0;
                end
            end
            S_SFD: begin
                gmii_tx_en = 1'b1;
                gmii_txd   = 8'hD5;
                state_nxt  = S_DATA;
                cnt_nxt    = 8'd0;
            end
            S_DATA: begin
                gmii_tx_en = 1'b1;
                gmii_txd   = data_byte;
                if (cnt == 8'd59) begin
                    state_nxt = S_FCS;
                    cnt_nxt   = 8'd0;
                end
            end
            S_FCS: begin
                gmii_tx_en = 1'b1;
                case (cnt[1:0])
                    2'd0:    gmii_txd = fcs[7:0];
                    2'd1:    gmii_txd = fcs[15:8];
                    2'd2:    gmii_txd = fcs[23:16];
                    default: gmii_txd = fcs[31:24];
                endcase
                if (cnt == 8'd3) begin
                    tx_done   = 1'b1;
                    state_nxt = S_IFG;
                    cnt_nxt   = 8'd0;
                end
            end
            S_IFG: begin
                if (cnt == IFG_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 8'd0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_ptp_tx_gen.sv
`timescale 1ns/1ps
// Directed bench for ptp_tx_gen: frame content, CRC, timing, back-to-back, reset.
module tb_ptp_tx_gen;

    logic        gmii_clk = 1'b0;
    logic        rst;
    logic [35:0] rtc_time_in;
    logic        tx_req;
    logic [3:0]  tx_msg_id;
    logic [15:0] tx_seq_id;
    logic        tx_busy;
    logic        tx_done;
    logic [35:0] tx_ts_out;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  fb[72];
    logic [7:0]  eb[60];
    int          done_at, done_cnt, en_cnt;
    logic [35:0] sfd_rtc, rtc0;

    logic        rtc_run = 1'b0;
    logic [35:0] rtc_fix = 36'd0;
    logic [35:0] rtc_cnt = 36'h1_3FFF_FF00;

    always #4 gmii_clk = ~gmii_clk;
    always @(posedge gmii_clk) rtc_cnt <= rtc_cnt + 36'd1;
    assign rtc_time_in = rtc_run ? rtc_cnt : rtc_fix;

    ptp_tx_gen #(.IFG_BYTES(12)) dut (
        .gmii_clk   (gmii_clk),
        .rst        (rst),
        .rtc_time_in(rtc_time_in),
        .tx_req     (tx_req),
        .tx_msg_id  (tx_msg_id),
        .tx_seq_id  (tx_seq_id),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_ts_out  (tx_ts_out),
        .gmii_tx_en (gmii_tx_en),
        .gmii_txd   (gmii_txd)
    );

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge gmii_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial bit-at-a-time 802.3 CRC (reflected, LSB first).
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Called in the first PRE cycle; records 72 cycles of line activity.
    task automatic collect;
        done_at = -1; done_cnt = 0; en_cnt = 0;
        for (int c = 0; c < 72; c++) begin
            fb[c] = gmii_txd;
            if (gmii_tx_en) en_cnt++;
            if (tx_done) begin done_cnt++; done_at = c; end
            if (c == 0) rtc0 = rtc_time_in;
            if (c == 7) sfd_rtc = rtc_time_in;
            step;
        end
    endtask

    task automatic start(input logic [3:0] msg, input logic [15:0] seq);
        tx_msg_id = msg; tx_seq_id = seq; tx_req = 1'b1;
        step;
        tx_req = 1'b0;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (tx_busy && n < 300) begin step; n++; end
        chk("idle_wait", {63'd0, tx_busy}, 64'd0);
    endtask

    task automatic check_frame(input string tag, input logic [3:0] msg,
                               input logic [15:0] seq, input logic [35:0] ts);
        logic [31:0] crc, rv;
        int errs;
        foreach (eb[i]) eb[i] = 8'h00;
        eb[0] = 8'h01; eb[1] = 8'h1B; eb[2] = 8'h19;
        eb[6] = 8'h00; eb[7] = 8'h0A; eb[8] = 8'h35; eb[9] = 8'h00; eb[10] = 8'h01; eb[11] = 8'h02;
        eb[12] = 8'h88; eb[13] = 8'hF7;
        eb[14] = {4'h0, msg}; eb[15] = 8'h02; eb[17] = 8'h2C;
        eb[34] = 8'h00; eb[35] = 8'h0A; eb[36] = 8'h35; eb[37] = 8'hFF;
        eb[38] = 8'hFE; eb[39] = 8'h00; eb[40] = 8'h01; eb[41] = 8'h02;
        eb[43] = 8'h01;
        eb[44] = seq[15:8]; eb[45] = seq[7:0];
        eb[46] = (msg == 4'd0) ? 8'h00 : (msg == 4'd1) ? 8'h01 : 8'h05;
        eb[47] = 8'h7F;
        eb[53] = {2'b00, ts[35:30]};
        eb[54] = {2'b00, ts[29:24]}; eb[55] = ts[23:16]; eb[56] = ts[15:8]; eb[57] = ts[7:0];
        errs = 0;
        for (int i = 0; i < 7; i++) if (fb[i] !== 8'h55) errs++;
        if (fb[7] !== 8'hD5) errs++;
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < 60; i++) begin
            if (fb[8+i] !== eb[i]) errs++;
            crc = crc_upd(crc, eb[i]);
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) if (fb[68+i] !== crc[8*i +: 8]) errs++;
        chk({tag, "_bytes"}, 64'(errs), 64'd0);
        // Residue over dst..FCS as seen on the wire, bit-reversed to MSB-first form.
        crc = 32'hFFFF_FFFF;
        for (int i = 8; i < 72; i++) crc = crc_upd(crc, fb[i]);
        for (int i = 0; i < 32; i++) rv[i] = crc[31-i];
        chk({tag, "_residue"}, {32'd0, rv}, 64'h0000_0000_C704_DD7B);
    endtask

    initial begin
        int ifg_busy, idle_cnt, extra;
        rst = 1'b1; tx_req = 1'b0; tx_msg_id = 4'd0; tx_seq_id = 16'd0;
        step; step; step;
        chk("rst_busy", {63'd0, tx_busy}, 64'd0);
        chk("rst_done", {63'd0, tx_done}, 64'd0);
        chk("rst_ts",   {28'd0, tx_ts_out}, 64'd0);
        chk("rst_en",   {63'd0, gmii_tx_en}, 64'd0);
        chk("rst_txd",  {56'd0, gmii_txd}, 64'd0);
        rst = 1'b0;
        step; step;
        chk("idle_en", {63'd0, gmii_tx_en}, 64'd0);

        // T1: Sync, seq 1234, constant RTC. seconds = ts[35:30] = 8, ns = 0x10.
        rtc_fix = 36'h2_0000_0010;
        start(4'd0, 16'h1234);
        chk("t1_busy", {63'd0, tx_busy}, 64'd1);
        collect;
        chk("t1_pre",     {40'd0, fb[0], fb[6], fb[7]}, 64'h55_55_D5);
        chk("t1_en_len",  64'(en_cnt), 64'd72);
        chk("t1_done_at", 64'(done_at), 64'd71);
        chk("t1_done_n",  64'(done_cnt), 64'd1);
        chk("t1_ifg_en",  {63'd0, gmii_tx_en}, 64'd0);
        chk("t1_ifg_bsy", {63'd0, tx_busy}, 64'd1);
        chk("t1_seq",     {48'd0, fb[52], fb[53]}, 64'h1234);
        chk("t1_ctrl",    {56'd0, fb[54]}, 64'h00);
        chk("t1_tsbytes", {24'd0, fb[61], fb[62], fb[63], fb[64], fb[65]}, 64'h08_0000_0010);
        chk("t1_ts_out",  {28'd0, tx_ts_out}, 64'h2_0000_0010);
        check_frame("t1", 4'd0, 16'h1234, 36'h2_0000_0010);
        wait_idle;

        // T3: Delay_Req, seq FFFF.
        start(4'd1, 16'hFFFF);
        collect;
        chk("t3_msg",  {56'd0, fb[22]}, 64'h01);
        chk("t3_ctrl", {56'd0, fb[54]}, 64'h01);
        chk("t3_seq",  {48'd0, fb[52], fb[53]}, 64'hFFFF);
        chk("t3_len",  {48'd0, fb[24], fb[25]}, 64'h002C);
        check_frame("t3", 4'd1, 16'hFFFF, 36'h2_0000_0010);
        wait_idle;

        // T4: request held high. The gap is 12 IFG cycles (busy) plus one idle
        // accept cycle (busy low) before the next preamble.
        tx_msg_id = 4'd3; tx_seq_id = 16'h0042; tx_req = 1'b1;
        step;
        collect;
        ifg_busy = 0; idle_cnt = 0;
        for (int c = 0; c < 300 && !gmii_tx_en; c++) begin
            if (tx_busy) ifg_busy++; else idle_cnt++;
            step;
        end
        chk("t4_ifg",    64'(ifg_busy), 64'd12);
        chk("t4_idle",   64'(idle_cnt), 64'd1);
        chk("t4_restart", {63'd0, gmii_tx_en}, 64'd1);
        tx_req = 1'b0;
        collect;
        check_frame("t4", 4'd3, 16'h0042, 36'h2_0000_0010);
        chk("t4_ctrl5", {56'd0, fb[54]}, 64'h05);
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            if (gmii_tx_en) extra++;
            step;
        end
        chk("t4_no_extra", 64'(extra), 64'd0);

        // T5: RTC advancing every cycle; SFD is 7 cycles after the first preamble byte.
        rtc_run = 1'b1;
        start(4'd0, 16'h0505);
        collect;
        chk("t5_sfd_rtc", {28'd0, sfd_rtc}, {28'd0, rtc0 + 36'd7});
        chk("t5_ts_out",  {28'd0, tx_ts_out}, {28'd0, rtc0 + 36'd7});
        check_frame("t5", 4'd0, 16'h0505, rtc0 + 36'd7);
        rtc_run = 1'b0;
        wait_idle;

        // T6: reset at DATA byte 20 for 3 cycles.
        start(4'd0, 16'h0006);
        for (int c = 0; c < 28; c++) step;
        chk("t6_mid_en", {63'd0, gmii_tx_en}, 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_en",   {63'd0, gmii_tx_en}, 64'd0);
        chk("t6_rst_txd",  {56'd0, gmii_txd}, 64'd0);
        chk("t6_rst_busy", {63'd0, tx_busy}, 64'd0);
        done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            step;
            if (tx_done || gmii_tx_en) done_cnt++;
        end
        chk("t6_quiet", 64'(done_cnt), 64'd0);
        rst = 1'b0;
        step;
        chk("t6_idle", {63'd0, tx_busy}, 64'd0);
        start(4'd0, 16'h0007);
        collect;
        chk("t6_done_at", 64'(done_at), 64'd71);
        check_frame("t6", 4'd0, 16'h0007, 36'h2_0000_0010);
        wait_idle;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
